// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the MEM -> WB slice of the pipeline.
//   stateT      : MEM-stage sequencer states (IDLE, WAIT, DONE)
//   DW_DEF      : default data/address width
//   RW_DEF      : default register-number width
//   TIMEOUT_DEF : default number of cycles to wait for dm_ack
//   wbBundleT   : the writeback bundle handed to the WB stage
//   makeWb()    : packs loose fields into a wbBundleT
// The bundle struct is sized by DW_DEF/RW_DEF, so a different datapath width
// is obtained by changing the package defaults rather than the module
// parameters alone.
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int DW_DEF      = 32;
  localparam int RW_DEF      = 5;
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,   // waiting for the next instruction
    WAIT = 2'd1,   // memory request outstanding
    DONE = 2'd2    // read data captured, WB loads on the next enabled edge
  } stateT;

  typedef struct packed {
    logic [DW_DEF-1:0] pc;
    logic              reg_mem_sel;
    logic              reg_wr;
    logic [DW_DEF-1:0] data;
    logic [RW_DEF-1:0] reg_num;
  } wbBundleT;

  function automatic wbBundleT makeWb(
    input logic [DW_DEF-1:0] pc,
    input logic              regMemSel,
    input logic              regWr,
    input logic [DW_DEF-1:0] data,
    input logic [RW_DEF-1:0] regNum
  );
    wbBundleT b;
    b.pc          = pc;
    b.reg_mem_sel = regMemSel;
    b.reg_wr      = regWr;
    b.data        = data;
    b.reg_num     = regNum;
    return b;
  endfunction

endpackage

// File: rtl/mem_to_wb_stage_if.sv
// -----------------------------------------------------------------------------
// mem_to_wb_stage_if
// Data-memory request/acknowledge bus between the MEM stage and the memory.
//   dm_req   : request, held high until dm_ack
//   dm_we    : write strobe (1 = store), qualified by dm_req
//   dm_addr  : word-aligned address, stable while dm_req is high
//   dm_wdata : store data, stable while dm_req is high
//   dm_rdata : read data, valid in the cycle dm_ack is high
//   dm_ack   : completion, one cycle
// Modports: master = MEM stage, slave = memory.
// -----------------------------------------------------------------------------
interface mem_to_wb_stage_if #(
  parameter int DW = 32
) ();

  logic          dm_req;
  logic          dm_we;
  logic [DW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_ack;

  modport master (
    output dm_req,
    output dm_we,
    output dm_addr,
    output dm_wdata,
    input  dm_rdata,
    input  dm_ack
  );

  modport slave (
    input  dm_req,
    input  dm_we,
    input  dm_addr,
    input  dm_wdata,
    output dm_rdata,
    output dm_ack
  );

endinterface

// File: rtl/dmem_req_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_req_ctrl
// Sequencer for one data-memory access: FSM, timeout counter and the
// registered dm_* request outputs.
//   clk, rst_n  : clock, asynchronous active-low reset
//   en, flush   : pipeline advance / discard the current instruction
//   memEn       : instruction accesses memory
//   memWr       : 1 = store, 0 = load
//   memAddr     : access address (low two bits must be zero)
//   memVal      : store data
//   dm          : memory bus (master side)
//   state       : current sequencer state
//   startAcc    : combinational, an aligned access starts this cycle
//   timeoutHit  : combinational, this is the last WAIT cycle and no ack came
//   rdataCap    : read data captured on dm_ack
//   memErr      : one-cycle pulse after a misaligned access or a timeout
// -----------------------------------------------------------------------------
module dmem_req_ctrl
  import cpu_pkg::*;
#(
  parameter int DW          = DW_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              flush,
  input  logic              memEn,
  input  logic              memWr,
  input  logic [DW-1:0]     memAddr,
  input  logic [DW-1:0]     memVal,
  mem_to_wb_stage_if.master dm,
  output stateT             state,
  output logic              startAcc,
  output logic              timeoutHit,
  output logic [DW-1:0]     rdataCap,
  output logic              memErr
);

  localparam int            CW       = $clog2(TIMEOUT_CYC + 1);
  // Value the counter holds during the final allowed WAIT cycle.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] CNT_SAT  = CW'(TIMEOUT_CYC);

  stateT         stateReg,  stateNext;
  logic [CW-1:0] cntReg,    cntNext;
  logic          reqReg,    reqNext;
  logic          weReg,     weNext;
  logic [DW-1:0] addrReg,   addrNext;
  logic [DW-1:0] wdataReg,  wdataNext;
  logic [DW-1:0] rdataReg,  rdataNext;
  logic          errReg,    errNext;
  logic          misaligned;

  assign misaligned = (memAddr[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg <= IDLE;
      cntReg   <= '0;
      reqReg   <= 1'b0;
      weReg    <= 1'b0;
      addrReg  <= '0;
      wdataReg <= '0;
      rdataReg <= '0;
      errReg   <= 1'b0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
      reqReg   <= reqNext;
      weReg    <= weNext;
      addrReg  <= addrNext;
      wdataReg <= wdataNext;
      rdataReg <= rdataNext;
      errReg   <= errNext;
    end
  end

  always_comb begin
    stateNext  = stateReg;
    cntNext    = cntReg;
    reqNext    = reqReg;
    weNext     = weReg;
    addrNext   = addrReg;
    wdataNext  = wdataReg;
    rdataNext  = rdataReg;
    errNext    = 1'b0;
    startAcc   = 1'b0;
    timeoutHit = 1'b0;

    case (stateReg)
      IDLE: begin
        cntNext = '0;
        // flush outranks the memory access; a late ack here is ignored.
        if (en && !flush && memEn) begin
          if (misaligned) begin
            errNext = 1'b1;
          end else begin
            startAcc  = 1'b1;
            reqNext   = 1'b1;
            weNext    = memWr;
            addrNext  = memAddr;
            wdataNext = memVal;
            stateNext = WAIT;
          end
        end
      end

      WAIT: begin
        if (cntReg != CNT_SAT) begin
          cntNext = cntReg + CW'(1);
        end
        // An ack in the last allowed cycle still wins over the timeout.
        if (dm.dm_ack) begin
          reqNext   = 1'b0;
          weNext    = 1'b0;
          rdataNext = dm.dm_rdata;
          stateNext = DONE;
        end else if (cntReg == CNT_LAST) begin
          timeoutHit = 1'b1;
          reqNext    = 1'b0;
          weNext     = 1'b0;
          errNext    = 1'b1;
          stateNext  = IDLE;
        end
      end

      DONE: begin
        if (en) begin
          stateNext = IDLE;
        end
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  assign state       = stateReg;
  assign rdataCap    = rdataReg;
  assign memErr      = errReg;
  assign dm.dm_req   = reqReg;
  assign dm.dm_we    = weReg;
  assign dm.dm_addr  = addrReg;
  assign dm.dm_wdata = wdataReg;

endmodule

// File: rtl/mem_to_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_to_wb_stage
// MEM-stage sequencer plus MEM/WB pipeline register.
//   clk, rst_n      : clock, asynchronous active-low reset
//   en              : pipeline advance; 0 holds the WB outputs
//   flush           : discard the current instruction
//   in_*            : EX/MEM bundle (pc, data select, reg write, memory
//                     enable/direction, store data, address, ALU result,
//                     destination register)
//   stall           : hold EX/MEM and earlier stages
//   dm              : data-memory request/ack bus (master side)
//   wb_*            : registered writeback bundle for the WB stage
//   mem_err         : one-cycle pulse on a misaligned access or a timeout
// Memory accesses run through dmem_req_ctrl; this level keeps the latched
// instruction, the WB register and the stall/flush bookkeeping.
// -----------------------------------------------------------------------------
module mem_to_wb_stage
  import cpu_pkg::*;
#(
  parameter int DW          = DW_DEF,
  parameter int RW          = RW_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              flush,
  input  logic [DW-1:0]     in_pc,
  input  logic              in_reg_mem_sel,
  input  logic              in_reg_wr,
  input  logic              in_mem_en,
  input  logic              in_mem_wr,
  input  logic [DW-1:0]     in_mem_val,
  input  logic [DW-1:0]     in_mem_addr,
  input  logic [DW-1:0]     in_alu_res,
  input  logic [RW-1:0]     in_reg_num,
  output logic              stall,
  mem_to_wb_stage_if.master dm,
  output logic [DW-1:0]     wb_pc,
  output logic              wb_reg_mem_sel,
  output logic              wb_reg_wr,
  output logic [DW-1:0]     wb_data,
  output logic [RW-1:0]     wb_reg_num,
  output logic              mem_err
);

  stateT         state;
  logic          startAcc;
  logic          timeoutHit;
  logic [DW-1:0] rdataCap;

  wbBundleT      wbReg;
  wbBundleT      wbNext;
  logic          wbLoad;
  wbBundleT      latchReg;      // memory instruction, data field = ALU result
  logic          latchMemWr;
  logic          flushSticky;

  dmem_req_ctrl #(
    .DW          (DW),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .flush      (flush),
    .memEn      (in_mem_en),
    .memWr      (in_mem_wr),
    .memAddr    (in_mem_addr),
    .memVal     (in_mem_val),
    .dm         (dm),
    .state      (state),
    .startAcc   (startAcc),
    .timeoutHit (timeoutHit),
    .rdataCap   (rdataCap),
    .memErr     (mem_err)
  );

  // WB register next value. In IDLE the WB register follows the EX/MEM
  // inputs unless an aligned access is starting; any memory op that does
  // not start (flushed or misaligned) becomes a bubble.
  always_comb begin
    wbLoad = 1'b0;
    wbNext = wbReg;
    case (state)
      IDLE: begin
        if (en && !startAcc) begin
          wbLoad = 1'b1;
          wbNext = makeWb(in_pc, in_reg_mem_sel,
                          in_reg_wr & ~flush & ~in_mem_en,
                          in_alu_res, in_reg_num);
        end
      end
      WAIT: begin
        // An aborted access retires as a bubble even when en is low, so the
        // WB stage never sees a half-finished instruction.
        if (timeoutHit) begin
          wbLoad        = 1'b1;
          wbNext        = latchReg;
          wbNext.reg_wr = 1'b0;
        end
      end
      DONE: begin
        if (en) begin
          wbLoad = 1'b1;
          wbNext = latchReg;
          if (latchReg.reg_mem_sel) begin
            wbNext.data = rdataCap;
          end
          wbNext.reg_wr = latchReg.reg_wr & ~latchMemWr & ~(flushSticky | flush);
        end
      end
      default: begin
        wbLoad = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbReg       <= '0;
      latchReg    <= '0;
      latchMemWr  <= 1'b0;
      flushSticky <= 1'b0;
    end else begin
      if (startAcc) begin
        latchReg   <= makeWb(in_pc, in_reg_mem_sel, in_reg_wr,
                             in_alu_res, in_reg_num);
        latchMemWr <= in_mem_wr;
      end
      if (wbLoad) begin
        wbReg <= wbNext;
      end
      // A flush during an access cannot cancel the bus transfer; remember it
      // so the result is dropped at retirement. Cleared whenever the
      // sequencer returns to IDLE.
      if ((state == WAIT && timeoutHit) || (state == DONE && en)) begin
        flushSticky <= 1'b0;
      end else if (state != IDLE && flush) begin
        flushSticky <= 1'b1;
      end
    end
  end

  // Stall covers the start cycle, the whole wait, and a DONE held by en=0.
  // After a timeout the aborted instruction is still presented in the next
  // IDLE cycle alongside mem_err, so the upstream squashes it with flush.
  assign stall = rst_n & (startAcc | (state == WAIT) | ((state == DONE) & ~en));

  assign wb_pc          = wbReg.pc;
  assign wb_reg_mem_sel = wbReg.reg_mem_sel;
  assign wb_reg_wr      = wbReg.reg_wr;
  assign wb_data        = wbReg.data;
  assign wb_reg_num     = wbReg.reg_num;

endmodule

// File: tb/tb_mem_to_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_to_wb_stage
// Directed scenarios with literal expectations, then randomized traffic with a
// random-latency memory responder. A transaction-level model tracks what the
// stage owes the WB stage and the memory bus; one compare process checks all
// outputs one time unit before every rising edge.
// -----------------------------------------------------------------------------
module tb_mem_to_wb_stage;
  import cpu_pkg::*;

  localparam int TMO = 4;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        flush;
  logic [31:0] inPc;
  logic        inSel;
  logic        inRegWr;
  logic        inMemEn;
  logic        inMemWr;
  logic [31:0] inMemVal;
  logic [31:0] inMemAddr;
  logic [31:0] inAlu;
  logic [4:0]  inRegNum;
  logic        stall;
  logic [31:0] wbPc;
  logic        wbSel;
  logic        wbRegWr;
  logic [31:0] wbData;
  logic [4:0]  wbRegNum;
  logic        memErr;

  int nTotal = 0;
  int nPass  = 0;

  mem_to_wb_stage_if #(.DW(32)) dmIf ();

  mem_to_wb_stage #(
    .DW          (32),
    .RW          (5),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .flush          (flush),
    .in_pc          (inPc),
    .in_reg_mem_sel (inSel),
    .in_reg_wr      (inRegWr),
    .in_mem_en      (inMemEn),
    .in_mem_wr      (inMemWr),
    .in_mem_val     (inMemVal),
    .in_mem_addr    (inMemAddr),
    .in_alu_res     (inAlu),
    .in_reg_num     (inRegNum),
    .stall          (stall),
    .dm             (dmIf),
    .wb_pc          (wbPc),
    .wb_reg_mem_sel (wbSel),
    .wb_reg_wr      (wbRegWr),
    .wb_data        (wbData),
    .wb_reg_num     (wbRegNum),
    .mem_err        (memErr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTotal++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------- model
  bit          mBusy, mRetire, mSticky;
  int          mWaited;
  logic [31:0] mLpc, mLalu, mRd;
  logic        mLsel, mLwr, mLmemWr;
  logic [4:0]  mLnum;
  logic        eReq, eWe, eSel, eWr, eErr;
  logic [31:0] eAddr, eWdata, ePc, eData;
  logic [4:0]  eNum;

  always @(negedge clk) begin : cmp
    logic expStall, errN;
    #4;
    if (!rst_n) begin
      mBusy = 0; mRetire = 0; mSticky = 0; mWaited = 0;
      eReq = 0; eWe = 0; eAddr = 0; eWdata = 0; eErr = 0;
      ePc = 0; eSel = 0; eWr = 0; eData = 0; eNum = 0;
      expStall = 0;
    end else begin
      expStall = mBusy || (mRetire && !en) ||
                 (!mBusy && !mRetire && en && !flush && inMemEn && inMemAddr[1:0] == 2'b00);
    end
    chk("stall", 32'(stall), 32'(expStall));
    chk("dm_req", 32'(dmIf.dm_req), 32'(eReq));
    chk("dm_we", 32'(dmIf.dm_we), 32'(eWe));
    if (eReq) begin
      chk("dm_addr", dmIf.dm_addr, eAddr);
      chk("dm_wdata", dmIf.dm_wdata, eWdata);
    end
    chk("wb_pc", wbPc, ePc);
    chk("wb_reg_mem_sel", 32'(wbSel), 32'(eSel));
    chk("wb_reg_wr", 32'(wbRegWr), 32'(eWr));
    chk("wb_data", wbData, eData);
    chk("wb_reg_num", 32'(wbRegNum), 32'(eNum));
    chk("mem_err", 32'(memErr), 32'(eErr));

    // Advance the model across the coming rising edge.
    if (rst_n) begin
      errN = 0;
      if (!mBusy && !mRetire) begin
        if (en) begin
          if (!flush && inMemEn && inMemAddr[1:0] == 2'b00) begin
            mLpc = inPc; mLsel = inSel; mLwr = inRegWr; mLalu = inAlu;
            mLnum = inRegNum; mLmemWr = inMemWr;
            mBusy = 1; mWaited = 0;
            eReq = 1; eWe = inMemWr; eAddr = inMemAddr; eWdata = inMemVal;
          end else begin
            ePc = inPc; eSel = inSel; eWr = inRegWr && !flush && !inMemEn;
            eData = inAlu; eNum = inRegNum;
            errN = !flush && inMemEn;
          end
        end
      end else if (mBusy) begin
        if (flush) mSticky = 1;
        mWaited++;
        if (dmIf.dm_ack) begin
          mRd = dmIf.dm_rdata; mBusy = 0; mRetire = 1;
          eReq = 0; eWe = 0;
        end else if (mWaited == TMO) begin
          eReq = 0; eWe = 0; errN = 1;
          ePc = mLpc; eSel = mLsel; eWr = 0; eData = mLalu; eNum = mLnum;
          mBusy = 0; mSticky = 0;
        end
      end else begin
        if (en) begin
          ePc = mLpc; eSel = mLsel; eNum = mLnum;
          eData = mLsel ? mRd : mLalu;
          eWr = mLwr && !mLmemWr && !mSticky && !flush;
          mRetire = 0; mSticky = 0;
        end else if (flush) begin
          mSticky = 1;
        end
      end
      eErr = errN;
    end
  end

  // ------------------------------------------------------------- stimulus
  task automatic setInst(input logic [31:0] pc, input logic sel, input logic wr,
                         input logic memEn, input logic memWr, input logic [31:0] val,
                         input logic [31:0] addr, input logic [31:0] alu, input logic [4:0] num);
    en = 1; flush = 0;
    inPc = pc; inSel = sel; inRegWr = wr; inMemEn = memEn; inMemWr = memWr;
    inMemVal = val; inMemAddr = addr; inAlu = alu; inRegNum = num;
  endtask

  task automatic idleIn();
    en = 0; inMemEn = 0; flush = 0;
  endtask

  initial begin
    int reqCycles;
    logic [31:0] r;
    rst_n = 0; en = 0; flush = 0;
    inPc = 0; inSel = 0; inRegWr = 0; inMemEn = 0; inMemWr = 0;
    inMemVal = 0; inMemAddr = 0; inAlu = 0; inRegNum = 0;
    dmIf.dm_ack = 0; dmIf.dm_rdata = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    #1;
    chk("rst_wb_data", wbData, 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);

    // ALU op
    @(negedge clk); setInst(32'h10, 0, 1, 0, 0, 0, 0, 32'h1234, 5'd5);
    #1 chk("alu_stall", 32'(stall), 32'h0);
    @(negedge clk); idleIn();
    #1 chk("alu_wb_reg_wr", 32'(wbRegWr), 32'h1);
    chk("alu_wb_data", wbData, 32'h1234);
    chk("alu_wb_reg_num", 32'(wbRegNum), 32'h5);

    // Load, ack in the third WAIT cycle
    @(negedge clk); setInst(32'h40, 1, 1, 1, 0, 0, 32'h100, 32'h7, 5'd7);
    #1 chk("ld_stall_start", 32'(stall), 32'h1);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      dmIf.dm_ack = (i == 3);
      dmIf.dm_rdata = (i == 3) ? 32'hDEAD_BEEF : 32'h0;
      #1 chk("ld_dm_req", 32'(dmIf.dm_req), 32'h1);
      chk("ld_dm_addr", dmIf.dm_addr, 32'h100);
      chk("ld_stall_wait", 32'(stall), 32'h1);
    end
    @(negedge clk); dmIf.dm_ack = 0;
    #1 chk("ld_req_drop", 32'(dmIf.dm_req), 32'h0);
    chk("ld_done_stall", 32'(stall), 32'h0);
    @(negedge clk); idleIn();
    #1 chk("ld_wb_data", wbData, 32'hDEAD_BEEF);
    chk("ld_wb_sel", 32'(wbSel), 32'h1);
    chk("ld_wb_reg_wr", 32'(wbRegWr), 32'h1);

    // Store, immediate ack
    @(negedge clk); setInst(32'h44, 0, 1, 1, 1, 32'hA5A5_A5A5, 32'h204, 32'h9, 5'd3);
    @(negedge clk); dmIf.dm_ack = 1;
    #1 chk("st_dm_we", 32'(dmIf.dm_we), 32'h1);
    chk("st_dm_wdata", dmIf.dm_wdata, 32'hA5A5_A5A5);
    @(negedge clk); dmIf.dm_ack = 0;
    #1 chk("st_req_drop", 32'(dmIf.dm_req), 32'h0);
    chk("st_we_drop", 32'(dmIf.dm_we), 32'h0);
    @(negedge clk); idleIn();
    #1 chk("st_wb_reg_wr", 32'(wbRegWr), 32'h0);

    // Misaligned load
    @(negedge clk); setInst(32'h48, 1, 1, 1, 0, 0, 32'h102, 32'h5, 5'd9);
    @(negedge clk); idleIn();
    #1 chk("mis_dm_req", 32'(dmIf.dm_req), 32'h0);
    chk("mis_err", 32'(memErr), 32'h1);
    chk("mis_wb_reg_wr", 32'(wbRegWr), 32'h0);
    @(negedge clk);
    #1 chk("mis_err_pulse", 32'(memErr), 32'h0);

    // Timeout with a late ack
    @(negedge clk); setInst(32'h4C, 1, 1, 1, 0, 0, 32'h300, 32'h6, 5'd4);
    reqCycles = 0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      #1 if (dmIf.dm_req) reqCycles++;
    end
    @(negedge clk); idleIn(); dmIf.dm_ack = 1;
    #1 chk("tmo_req_cycles", 32'(reqCycles), 32'd4);
    chk("tmo_req_drop", 32'(dmIf.dm_req), 32'h0);
    chk("tmo_err", 32'(memErr), 32'h1);
    chk("tmo_wb_reg_wr", 32'(wbRegWr), 32'h0);
    @(negedge clk); dmIf.dm_ack = 0;
    #1 chk("tmo_late_ack_req", 32'(dmIf.dm_req), 32'h0);
    chk("tmo_late_ack_stall", 32'(stall), 32'h0);

    // Flush during a load wait
    @(negedge clk); setInst(32'h60, 1, 1, 1, 0, 0, 32'h180, 32'h2, 5'd6);
    @(negedge clk); flush = 1;
    @(negedge clk); flush = 0; dmIf.dm_ack = 1; dmIf.dm_rdata = 32'h1111;
    @(negedge clk); dmIf.dm_ack = 0;
    @(negedge clk); idleIn();
    #1 chk("fl_wb_reg_wr", 32'(wbRegWr), 32'h0);
    chk("fl_wb_data", wbData, 32'h1111);

    // Asynchronous reset in the middle of a wait
    @(negedge clk); setInst(32'h99, 1, 1, 1, 0, 0, 32'h80, 32'h1, 5'd2);
    @(negedge clk);
    #1 chk("rst_pre_req", 32'(dmIf.dm_req), 32'h1);
    #1 rst_n = 0;
    #1 chk("rst_async_req", 32'(dmIf.dm_req), 32'h0);
    chk("rst_async_pc", wbPc, 32'h0);
    chk("rst_async_stall", 32'(stall), 32'h0);
    @(negedge clk); rst_n = 1; idleIn();

    // Randomized traffic
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      rst_n = ($urandom_range(299) != 0);
      en = ($urandom_range(99) < 80);
      flush = ($urandom_range(99) < 10);
      inPc = $urandom; inAlu = $urandom; inMemVal = $urandom;
      inSel = 1'($urandom_range(1)); inRegWr = 1'($urandom_range(1));
      inMemEn = 1'($urandom_range(1)); inMemWr = 1'($urandom_range(1));
      inRegNum = 5'($urandom_range(31));
      r = $urandom;
      inMemAddr = {r[31:2], ($urandom_range(99) < 15) ? 2'($urandom_range(3, 1)) : 2'b00};
      dmIf.dm_ack = dmIf.dm_req ? ($urandom_range(99) < 35) : ($urandom_range(99) < 8);
      dmIf.dm_rdata = $urandom;
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule
